// File: rtl/rpn_pilha_pkg.sv
// Shared definitions for the RPN operand stack: opcodes, controller states and flag bit positions.
package rpn_pkg;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_SOMA = 3'b000;
  localparam opcode_t OP_SUB  = 3'b001;
  localparam opcode_t OP_MUL  = 3'b010;
  localparam opcode_t OP_DIV  = 3'b011;
  localparam opcode_t OP_AND  = 3'b100;
  localparam opcode_t OP_OR   = 3'b101;
  localparam opcode_t OP_XOR  = 3'b110;
  localparam opcode_t OP_NOT  = 3'b111;

  typedef enum logic [1:0] {
    OCIOSO,
    ALU,
    MUL,
    GRAVA
  } estado_t;

  localparam int unsigned FLAG_COUT    = 0;
  localparam int unsigned FLAG_ERRO    = 1;
  localparam int unsigned FLAG_RESTO   = 2;
  localparam int unsigned FLAG_MUL_OVF = 3;

endpackage

// File: rtl/rpn_pilha_if.sv
// Operand/result bus between the stack controller (master) and the 8-bit ALU (slave).
interface rpn_pilha_if;
  import rpn_pkg::*;

  logic [7:0] alu_a;
  logic [7:0] alu_b;
  opcode_t    alu_sel;
  logic       alu_cin;
  logic [7:0] alu_s;
  logic [2:0] alu_flags;

  modport master (
    output alu_a, alu_b, alu_sel, alu_cin,
    input  alu_s, alu_flags
  );

  modport slave (
    input  alu_a, alu_b, alu_sel, alu_cin,
    output alu_s, alu_flags
  );
endinterface

// File: rtl/multiplicador_seq.sv
// Unsigned 8x8 shift-add multiplier, one iteration per clock; only built when RPN_MUL_EN is defined.
module multiplicador_seq
  import rpn_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] produto,
  output logic        fim
);

  logic [15:0] acc;
  logic [15:0] mcand;
  logic [7:0]  mplier;
  logic [2:0]  cnt;
  logic        ativo;

  assign produto = acc;
  // High during the cycle whose closing edge performs the eighth iteration.
  assign fim = ativo && (cnt == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      ativo  <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      mcand  <= {8'h00, a};
      mplier <= b;
      cnt    <= '0;
      ativo  <= 1'b1;
    end else if (ativo) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= {mcand[14:0], 1'b0};
      mplier <= {1'b0, mplier[7:1]};
      cnt    <= cnt + 3'd1;
      if (cnt == 3'd7) ativo <= 1'b0;
    end
  end

endmodule

// File: rtl/rpn_pilha.sv
// RPN operand stack and execution controller feeding the external ALU.
// Define RPN_MUL_EN to build the sequential multiplier for opcode 010.
module rpn_pilha
  import rpn_pkg::*;
#(
  parameter int unsigned PROFUNDIDADE = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        entrada,
  input  logic                              push,
  input  logic                              exec,
  input  opcode_t                           op,
  input  logic                              cin_in,
  rpn_pilha_if.master                       alu,
  output logic [7:0]                        topo,
  output logic [$clog2(PROFUNDIDADE+1)-1:0] nivel,
  output logic                              ocupado,
  output logic                              pronto,
  output logic [3:0]                        flags,
  output logic                              erro_pilha
);

  localparam int unsigned NW = $clog2(PROFUNDIDADE + 1);
  localparam int unsigned IW = $clog2(PROFUNDIDADE);

  logic [7:0]    pilha [PROFUNDIDADE];
  estado_t       estado;
  logic [IW-1:0] idx_x;
  logic [IW-1:0] idx_y;
  logic [7:0]    val_x;
  logic [7:0]    val_y;
  logic          unario;
  logic          operandos_ok;

  always_comb begin
    idx_x        = IW'(nivel - NW'(1));
    idx_y        = IW'(nivel - NW'(2));
    val_x        = pilha[idx_x];
    val_y        = pilha[idx_y];
    unario       = (op == OP_NOT);
    operandos_ok = unario ? (nivel >= NW'(1)) : (nivel >= NW'(2));
    topo         = (nivel == '0) ? '0 : val_x;
  end

`ifdef RPN_MUL_EN
  logic        mul_start;
  logic        mul_fim;
  logic [15:0] produto;

  // Started combinationally so the first iteration lands on the edge after acceptance.
  assign mul_start = (estado == OCIOSO) && exec && (op == OP_MUL) && operandos_ok;

  multiplicador_seq u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (val_y),
    .b       (val_x),
    .produto (produto),
    .fim     (mul_fim)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < PROFUNDIDADE; i++) pilha[i] <= '0;
      nivel         <= '0;
      flags         <= '0;
      ocupado       <= 1'b0;
      pronto        <= 1'b0;
      erro_pilha    <= 1'b0;
      alu.alu_a     <= '0;
      alu.alu_b     <= '0;
      alu.alu_sel   <= '0;
      alu.alu_cin   <= 1'b0;
      estado        <= OCIOSO;
    end else begin
      pronto     <= 1'b0;
      erro_pilha <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (exec) begin
            if (!operandos_ok) begin
              erro_pilha <= 1'b1;
            end else begin
              alu.alu_a   <= unario ? val_x : val_y;
              alu.alu_b   <= unario ? 8'h00 : val_x;
              alu.alu_sel <= op;
              alu.alu_cin <= cin_in;
              ocupado     <= 1'b1;
`ifdef RPN_MUL_EN
              estado      <= (op == OP_MUL) ? MUL : ALU;
`else
              estado      <= ALU;
`endif
            end
          end else if (push) begin
            if (nivel < NW'(PROFUNDIDADE)) begin
              pilha[IW'(nivel)] <= entrada;
              nivel             <= nivel + NW'(1);
            end else begin
              erro_pilha <= 1'b1;
            end
          end
        end
        ALU: begin
          flags <= {1'b0, alu.alu_flags};
          // Divide by zero leaves both operands on the stack.
          if (!(alu.alu_sel == OP_DIV && alu.alu_flags[FLAG_ERRO])) begin
            if (alu.alu_sel == OP_NOT) begin
              pilha[idx_x] <= alu.alu_s;
            end else begin
              pilha[idx_y] <= alu.alu_s;
              nivel        <= nivel - NW'(1);
            end
          end
          pronto  <= 1'b1;
          ocupado <= 1'b0;
          estado  <= OCIOSO;
        end
`ifdef RPN_MUL_EN
        MUL: begin
          if (mul_fim) estado <= GRAVA;
        end
        GRAVA: begin
          pilha[idx_y] <= produto[7:0];
          nivel        <= nivel - NW'(1);
          flags        <= {|produto[15:8], 3'b000};
          pronto       <= 1'b1;
          ocupado      <= 1'b0;
          estado       <= OCIOSO;
        end
`endif
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule
